branch_resolver: RTL and testbench

Resolution end of the branch-prediction interface. Keeps an in-order queue of the predictions IF made for control instructions (JAL and B-type), one entry per instruction. It checks each EX outcome against the oldest queued prediction. It drives the predictor's training inputs (is_btype, jump_or_not, ex_pc_bus) and its kill input (failed), and gives IF the redirect PC on a mispredict.

---
 rtl/branch_resolver_pkg.sv | 18 +
 rtl/branch_resolver_pred_fifo.sv | 70 +++++++
 rtl/branch_resolver.sv | 120 ++++++++++++
 tb/tb_branch_resolver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch-resolution path: global widths, constants
// and the resolver's RUN/FLUSH state encoding.
package branch_resolver_pkg;

  localparam int unsigned AddrLen    = 32;
  localparam int unsigned InstLen    = 32;
  localparam int unsigned PredIdxLen = 4;

  localparam logic [AddrLen-1:0] ZERO_WORD = '0;
  localparam logic               True      = 1'b1;
  localparam logic               False     = 1'b0;

  typedef enum logic {
    StRun,
    StFlush
  } br_state_e;

endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// Parameterised synchronous FIFO holding in-flight branch predictions.
// A flush empties the queue and wins over a simultaneous push or pop.
module branch_resolver_pred_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CountMax = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CountMax);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PtrW + 1)'(1);
        2'b01:   count_d = count_q - (PtrW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolver.sv
// Checks EX branch outcomes against the oldest queued IF prediction, trains the
// predictor and redirects fetch with a one-cycle flush on a mispredict.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = AddrLen,
  parameter int unsigned IDX_W  = PredIdxLen
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rdy_i,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              if_is_btype_i,
  input  logic              if_pred_jump_i,
  input  logic [ADDR_W-1:0] if_pred_pc_i,
  input  logic              ex_valid_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  output logic              is_btype_o,
  output logic              jump_or_not_o,
  output logic [IDX_W-1:0]  ex_pc_bus_o,
  output logic              failed_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              full_o
);

  // Entry layout: {pc, btype, pred_jump, pred_pc}
  localparam int unsigned EntryW = 2 * ADDR_W + 2;

  br_state_e state_q, state_d;

  logic [EntryW-1:0] push_data, head_data;
  logic              fifo_empty;
  logic              push_ok, pop_ok, mispred;

  logic [ADDR_W-1:0] head_pc, head_pred_pc, correct_pc;
  logic              head_btype, head_pred_jump;

  logic              is_btype_q, is_btype_d;
  logic              jump_q, jump_d;
  logic [IDX_W-1:0]  pc_bus_q, pc_bus_d;
  logic              failed_q, failed_d;
  logic [ADDR_W-1:0] redirect_q, redirect_d;

  assign push_data = {if_pc_i, if_is_btype_i, if_pred_jump_i, if_pred_pc_i};
  assign {head_pc, head_btype, head_pred_jump, head_pred_pc} = head_data;

  // The FIFO drops a push when full, so the top need not gate on full here.
  assign push_ok = if_valid_i & rdy_i & (state_q == StRun);
  assign pop_ok  = ex_valid_i & rdy_i & ~fifo_empty & (state_q == StRun);

  assign mispred = pop_ok & ((head_pred_jump != ex_jump_i) |
                             (ex_jump_i & (head_pred_pc != ex_target_i)));
  assign correct_pc = ex_jump_i ? ex_target_i : head_pc + ADDR_W'(4);

  branch_resolver_pred_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_pred_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .flush_i (mispred),
    .wdata_i (push_data),
    .rdata_o (head_data),
    .full_o  (full_o),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    is_btype_d = False;
    jump_d     = False;
    pc_bus_d   = '0;
    failed_d   = False;
    redirect_d = ZERO_WORD[ADDR_W-1:0];

    unique case (state_q)
      StRun:   if (mispred) state_d = StFlush;
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase

    if (pop_ok) begin
      is_btype_d = head_btype;
      jump_d     = ex_jump_i;
      pc_bus_d   = head_pc[IDX_W+1:2];
      failed_d   = mispred;
      redirect_d = mispred ? correct_pc : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      is_btype_q <= 1'b0;
      jump_q     <= 1'b0;
      pc_bus_q   <= '0;
      failed_q   <= 1'b0;
      redirect_q <= '0;
    end else if (rdy_i) begin
      state_q    <= state_d;
      is_btype_q <= is_btype_d;
      jump_q     <= jump_d;
      pc_bus_q   <= pc_bus_d;
      failed_q   <= failed_d;
      redirect_q <= redirect_d;
    end
  end

  assign is_btype_o    = is_btype_q;
  assign jump_or_not_o = jump_q;
  assign ex_pc_bus_o   = pc_bus_q;
  assign failed_o      = failed_q;
  assign redirect_pc_o = redirect_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and randomized bench for branch_resolver against a queue-based
// reference model of the prediction/resolution protocol.
module tb_branch_resolver;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rdy, if_valid, if_is_btype, if_pred_jump, ex_valid, ex_jump;
  logic [31:0] if_pc, if_pred_pc, ex_target;
  logic        is_btype, jump_or_not, failed, full;
  logic [3:0]  ex_pc_bus;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  branch_resolver #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .IDX_W  (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rdy_i          (rdy),
    .if_valid_i     (if_valid),
    .if_pc_i        (if_pc),
    .if_is_btype_i  (if_is_btype),
    .if_pred_jump_i (if_pred_jump),
    .if_pred_pc_i   (if_pred_pc),
    .ex_valid_i     (ex_valid),
    .ex_jump_i      (ex_jump),
    .ex_target_i    (ex_target),
    .is_btype_o     (is_btype),
    .jump_or_not_o  (jump_or_not),
    .ex_pc_bus_o    (ex_pc_bus),
    .failed_o       (failed),
    .redirect_pc_o  (redirect_pc),
    .full_o         (full)
  );

  typedef struct {
    logic [31:0] pc;
    logic        bt;
    logic        pj;
    logic [31:0] pp;
  } ent_t;

  ent_t        mq[$];
  logic        m_flushing = 1'b0;
  logic        e_bt = 1'b0, e_j = 1'b0, e_f = 1'b0;
  logic [3:0]  e_bus = '0;
  logic [31:0] e_rpc = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference behaviour for one clock edge, evaluated on the pre-edge inputs.
  task automatic model_edge();
    ent_t h, e;
    logic was_full, mis;
    if (rst) begin
      mq.delete();
      m_flushing = 1'b0;
      {e_bt, e_j, e_f, e_bus, e_rpc} = '0;
    end else if (rdy) begin
      {e_bt, e_j, e_f, e_bus, e_rpc} = '0;
      if (m_flushing) begin
        m_flushing = 1'b0;
      end else begin
        was_full = (mq.size() == DEPTH);
        mis = 1'b0;
        if (ex_valid && mq.size() > 0) begin
          h = mq.pop_front();
          mis = (h.pj != ex_jump) || (ex_jump && h.pp != ex_target);
          e_bt = h.bt;
          e_j = ex_jump;
          e_bus = h.pc[5:2];
          e_f = mis;
          e_rpc = mis ? (ex_jump ? ex_target : h.pc + 32'd4) : 32'd0;
          if (mis) begin
            mq.delete();
            m_flushing = 1'b1;
          end
        end
        if (if_valid && !was_full && !mis) begin
          e.pc = if_pc; e.bt = if_is_btype; e.pj = if_pred_jump; e.pp = if_pred_pc;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic iv, input logic [31:0] ipc,
                      input logic ibt, input logic ipj, input logic [31:0] ipp,
                      input logic ev, input logic ej, input logic [31:0] et, input string tag);
    rst = r; rdy = rd; if_valid = iv; if_pc = ipc; if_is_btype = ibt; if_pred_jump = ipj;
    if_pred_pc = ipp; ex_valid = ev; ex_jump = ej; ex_target = et;
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".is_btype"}, {31'd0, is_btype}, {31'd0, e_bt});
    chk({tag, ".jump_or_not"}, {31'd0, jump_or_not}, {31'd0, e_j});
    chk({tag, ".ex_pc_bus"}, {28'd0, ex_pc_bus}, {28'd0, e_bus});
    chk({tag, ".failed"}, {31'd0, failed}, {31'd0, e_f});
    chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
    chk({tag, ".full"}, {31'd0, full}, {31'd0, mq.size() == DEPTH});
  endtask

  task automatic idle(input string tag);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic push(input logic [31:0] pc, input logic bt, input logic pj,
                      input logic [31:0] pp, input string tag);
    step(0, 1, 1, pc, bt, pj, pp, 0, 0, 0, tag);
  endtask

  task automatic pop(input logic ej, input logic [31:0] et, input string tag);
    step(0, 1, 0, 0, 0, 0, 0, 1, ej, et, tag);
  endtask

  initial begin
    logic        ej;
    logic [31:0] et;
    logic [31:0] pp_set [4];
    pp_set[0] = 32'h100; pp_set[1] = 32'h200; pp_set[2] = 32'h300; pp_set[3] = 32'h0;

    // Reset held two cycles while IF requests a push
    step(1, 1, 1, 32'h40, 1, 1, 32'h80, 0, 0, 0, "rst0");
    step(1, 1, 1, 32'h40, 1, 1, 32'h80, 1, 1, 32'h80, "rst1");
    chk("rst.full", {31'd0, full}, 32'd0);
    chk("rst.failed", {31'd0, failed}, 32'd0);

    // Correct B-type; first push after reset lands at head
    push(32'h100, 1, 1, 32'h140, "bt_push");
    pop(1, 32'h140, "bt_pop");
    chk("bt.is_btype", {31'd0, is_btype}, 32'd1);
    chk("bt.failed", {31'd0, failed}, 32'd0);
    idle("bt_idle");
    pop(0, 0, "bt_empty_pop");
    chk("bt.empty_no_pulse", {31'd0, is_btype}, 32'd0);

    // Direction mispredict with two younger entries queued
    push(32'h2C, 1, 1, 32'h60, "dir_p0");
    push(32'h30, 1, 0, 32'h0, "dir_p1");
    push(32'h34, 0, 1, 32'h90, "dir_p2");
    pop(0, 0, "dir_pop");
    chk("dir.redirect", redirect_pc, 32'h30);
    chk("dir.pc_bus", {28'd0, ex_pc_bus}, 32'hB);
    chk("dir.failed", {31'd0, failed}, 32'd1);
    step(0, 1, 1, 32'h50, 1, 1, 32'h70, 1, 1, 32'h70, "dir_flush_push");
    pop(1, 32'h70, "dir_after_flush_pop");
    chk("dir.flushed", {31'd0, is_btype | failed}, 32'd0);

    // JAL target mismatch
    push(32'h80, 0, 1, 32'h200, "jal_push");
    pop(1, 32'h204, "jal_pop");
    chk("jal.redirect", redirect_pc, 32'h204);
    chk("jal.is_btype", {31'd0, is_btype}, 32'd0);
    idle("jal_flush");

    // Fill, overflow, then wrap with alternating push/pop
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i) * 4, 1, 0, 0, "full_push");
    chk("full.flag", {31'd0, full}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) pop(mq[0].pj, mq[0].pp, "wrap_pop");
      else push(32'h500 + 32'(i) * 4, 1, 1, 32'h100, "wrap_push");
    end
    while (mq.size() > 0) pop(mq[0].pj, mq[0].pp, "drain_pop");

    // rdy freeze holds outputs and state
    push(32'h3C, 1, 1, 32'h100, "rdy_push");
    push(32'h44, 1, 0, 32'h0, "rdy_push2");
    pop(1, 32'h100, "rdy_pop");
    step(0, 0, 1, 32'h48, 1, 1, 32'h0, 1, 1, 32'h0, "rdy_hold0");
    chk("rdy.held_bus", {28'd0, ex_pc_bus}, 32'hF);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "rdy_hold1");
    pop(0, 0, "rdy_resume_pop");
    chk("rdy.resume_bus", {28'd0, ex_pc_bus}, 32'h1);
    idle("rdy_idle");
    pop(1, 32'h0, "underflow");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        ej = mq[0].pj;
        et = mq[0].pp;
        if ($urandom_range(0, 7) == 0) ej = ~ej;
      end else begin
        ej = 1'($urandom);
        et = pp_set[$urandom_range(0, 3)];
      end
      step($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0, 1'($urandom),
           {22'd0, 8'($urandom), 2'b00}, 1'($urandom), 1'($urandom),
           pp_set[$urandom_range(0, 3)], 1'($urandom), ej, et, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
